// File: rtl/piano_pkg.sv
// Shared tone constants: half-period table (100 MHz clock) and mode encodings.
package piano_pkg;

    localparam int unsigned SCALE_LEN = 8;
    localparam int unsigned SCALE_W   = 3;

    localparam logic [1:0] MODE_PRIO = 2'b00;
    localparam logic [1:0] MODE_LAST = 2'b01;
    localparam logic [1:0] MODE_ARP  = 2'b10;

    // C4..C5 major scale, half-period in 100 MHz cycles
    localparam logic [31:0] HALF_PERIOD [SCALE_LEN] = '{
        32'd191113, 32'd170262, 32'd151686, 32'd143173,
        32'd127553, 32'd113636, 32'd101239, 32'd95557
    };

    // Keys past the first scale repeat it one octave higher per wrap
    function automatic logic [31:0] half_period(input int unsigned idx);
        return HALF_PERIOD[SCALE_W'(idx % SCALE_LEN)] >> (idx / SCALE_LEN);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: FREQ toggles every 'limit' enabled cycles, restartable.
module tone_divider #(
    parameter int unsigned CNT_W = 18
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [CNT_W-1:0] limit,
    input  logic             restart,
    input  logic             enable,
    output logic             FREQ
);
    logic [CNT_W-1:0] cnt;
    logic             wrap_c;

    // cnt+1 >= limit is cnt >= limit-1 without underflow when limit is 0
    assign wrap_c = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= {1'b0, limit};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt  <= '0;
            FREQ <= 1'b0;
        end else if (!enable || restart) begin
            cnt  <= '0;
            FREQ <= 1'b0;
        end else if (wrap_c) begin
            cnt  <= '0;
            FREQ <= ~FREQ;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/poly_tone_gen.sv
// Keyboard tone generator: selects one held key by priority, last-pressed or arpeggio rules.
module poly_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS  = 8,
    parameter int unsigned CNT_W     = 18,
    parameter int unsigned ARP_TICKS = 5000000,
    parameter int unsigned IDX_W     = $clog2(NUM_KEYS)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [1:0]          mode,
    input  logic [1:0]          octave,
    output logic                FREQ,
    output logic                note_valid,
    output logic [IDX_W-1:0]    note_idx,
    output logic [NUM_KEYS-1:0] Led
);
    localparam int unsigned       TICK_W    = (ARP_TICKS > 1) ? $clog2(ARP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ARP_TICKS - 1);

    logic [NUM_KEYS-1:0] keys_meta, ks, ks_prev, rise_c;
    logic [1:0]          mode_q, mode_eff_c;
    logic                mode_chg_c;
    logic [IDX_W-1:0]    sel_q, sel_n;
    logic                sel_valid_q, sel_valid_n;
    logic [TICK_W-1:0]   tick_q, tick_n;
    logic [CNT_W-1:0]    limit_c;
    logic                restart_c;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--)
            if (v[IDX_W'(i)]) r = IDX_W'(i);
        return r;
    endfunction

    // Next held key above cur, wrapping to the lowest held key
    function automatic logic [IDX_W-1:0] next_above(input logic [NUM_KEYS-1:0] v,
                                                    input logic [IDX_W-1:0]    cur);
        logic [IDX_W-1:0] r;
        r = lowest(v);
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--)
            if (v[IDX_W'(i)] && (i > int'(cur))) r = IDX_W'(i);
        return r;
    endfunction

    assign rise_c     = ks & ~ks_prev;
    assign mode_chg_c = (mode != mode_q);
    assign mode_eff_c = (mode == MODE_LAST || mode == MODE_ARP) ? mode : MODE_PRIO;

    // Selection next-state
    always_comb begin
        sel_n       = sel_q;
        sel_valid_n = 1'b1;
        tick_n      = '0;
        if (ks == '0) begin
            sel_n       = '0;
            sel_valid_n = 1'b0;
        end else begin
            case (mode_eff_c)
                MODE_LAST: begin
                    if (rise_c != '0)
                        sel_n = lowest(rise_c);
                    else if (!sel_valid_q || mode_chg_c || !ks[sel_q])
                        sel_n = lowest(ks);
                end
                MODE_ARP: begin
                    if (!sel_valid_q || mode_chg_c)
                        sel_n = lowest(ks);
                    else if (!ks[sel_q] || tick_q == TICK_LAST)
                        sel_n = next_above(ks, sel_q);
                    else
                        tick_n = tick_q + TICK_W'(1);
                end
                default: sel_n = lowest(ks);
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            keys_meta   <= '0;
            ks          <= '0;
            ks_prev     <= '0;
            mode_q      <= MODE_PRIO;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            tick_q      <= '0;
            note_valid  <= 1'b0;
            note_idx    <= '0;
            Led         <= '0;
        end else begin
            keys_meta   <= keys;
            ks          <= keys_meta;
            ks_prev     <= ks;
            mode_q      <= mode;
            sel_q       <= sel_n;
            sel_valid_q <= sel_valid_n;
            tick_q      <= tick_n;
            note_valid  <= sel_valid_q;
            note_idx    <= sel_q;
            Led         <= sel_valid_q ? (NUM_KEYS'(1) << sel_q) : '0;
        end
    end

    // A new note starts its first half-cycle from zero on the edge it appears
    assign restart_c = sel_valid_q && (!note_valid || (sel_q != note_idx));
    assign limit_c   = CNT_W'(half_period(32'(note_idx)) >> octave);

    tone_divider #(
        .CNT_W (CNT_W)
    ) u_tone (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .limit   (limit_c),
        .restart (restart_c),
        .enable  (sel_valid_q),
        .FREQ    (FREQ)
    );

endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: vector table, multi-cycle corner sequences and a randomized model run.
module tb_poly_tone_gen;

    localparam int ARP = 16;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] keys;
    logic [1:0] mode;
    logic [1:0] octave;
    logic       FREQ;
    logic       note_valid;
    logic [2:0] note_idx;
    logic [7:0] Led;

    int n_checks = 0;
    int n_pass   = 0;

    int HP [8] = '{191113, 170262, 151686, 143173, 127553, 113636, 101239, 95557};

    poly_tone_gen #(
        .NUM_KEYS  (8),
        .CNT_W     (18),
        .ARP_TICKS (ARP),
        .IDX_W     (3)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .keys       (keys),
        .mode       (mode),
        .octave     (octave),
        .FREQ       (FREQ),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .Led        (Led)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] keys;
        logic [1:0] mode;
        logic       exp_valid;
        logic [2:0] exp_idx;
    } vec_t;

    // reference model state
    logic [7:0] p1, p2, p3;
    int         m_sel, m_tick, age, e_idx;
    bit         m_valid, e_valid, e_freq;
    logic [1:0] m_mode_prev;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_clear();
        p1 = '0; p2 = '0; p3 = '0;
        m_sel = 0; m_tick = 0; age = 0; e_idx = 0;
        m_valid = 0; e_valid = 0; e_freq = 0;
        m_mode_prev = 2'b00;
    endtask

    // One clock edge of the behavioural model, using the inputs present at the edge
    task automatic model_step();
        int  held[$];
        int  rise[$];
        int  ns, nt, lim;
        bit  nv, mchg;
        if (!m_valid) age = 0;
        else if (!e_valid || m_sel != e_idx) age = 0;
        else age++;
        e_valid = m_valid;
        e_idx   = m_sel;
        lim     = HP[e_idx] >> octave;
        e_freq  = e_valid && (((age / lim) % 2) == 1);
        for (int i = 0; i < 8; i++) begin
            if (p2[i]) held.push_back(i);
            if (p2[i] && !p3[i]) rise.push_back(i);
        end
        mchg = (mode != m_mode_prev);
        nv = (held.size() > 0);
        ns = m_sel;
        nt = 0;
        if (!nv) ns = 0;
        else if (mode == 2'b01) begin
            if (rise.size() > 0) ns = rise[0];
            else if (!m_valid || mchg || !p2[m_sel]) ns = held[0];
        end else if (mode == 2'b10) begin
            if (!m_valid || mchg) ns = held[0];
            else if (!p2[m_sel] || m_tick == ARP - 1) begin
                ns = held[0];
                foreach (held[j]) if (held[j] > m_sel) begin ns = held[j]; break; end
            end else nt = m_tick + 1;
        end else ns = held[0];
        m_sel = ns; m_valid = nv; m_tick = nt; m_mode_prev = mode;
        p3 = p2; p2 = p1; p1 = keys;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        keys = '0; mode = 2'b00; octave = 2'b00;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!note_valid && n < 20) begin @(negedge CLK); n++; end
        if (!note_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_change(output int n);
        logic [2:0] prev;
        prev = note_idx;
        n = 0;
        do begin @(negedge CLK); n++; end while (note_idx == prev && n < 64);
    endtask

    task automatic run_len(input logic lvl, input int max, output int len);
        len = 0;
        while (FREQ == lvl && len < max) begin len++; @(negedge CLK); end
    endtask

    initial begin
        vec_t vecs [14];
        int   n, len, bad, hold;
        logic [7:0] el;

        vecs[0]  = '{8'h00, 2'b00, 1'b0, 3'd0};
        vecs[1]  = '{8'h01, 2'b00, 1'b1, 3'd0};
        vecs[2]  = '{8'h06, 2'b00, 1'b1, 3'd1};
        vecs[3]  = '{8'h80, 2'b11, 1'b1, 3'd7};
        vecs[4]  = '{8'hF0, 2'b11, 1'b1, 3'd4};
        vecs[5]  = '{8'h00, 2'b01, 1'b0, 3'd0};
        vecs[6]  = '{8'h20, 2'b01, 1'b1, 3'd5};
        vecs[7]  = '{8'h24, 2'b01, 1'b1, 3'd2};
        vecs[8]  = '{8'h20, 2'b01, 1'b1, 3'd5};
        vecs[9]  = '{8'h00, 2'b01, 1'b0, 3'd0};
        vecs[10] = '{8'h48, 2'b01, 1'b1, 3'd3};
        vecs[11] = '{8'h40, 2'b01, 1'b1, 3'd6};
        vecs[12] = '{8'h41, 2'b01, 1'b1, 3'd0};
        vecs[13] = '{8'hFF, 2'b00, 1'b1, 3'd0};

        RESET_N = 1'b0; keys = '0; mode = '0; octave = '0;
        do_reset();
        @(negedge CLK);
        chk("rst_valid", note_valid, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_led", Led, 0);
        chk("rst_freq", FREQ, 0);

        // first-note latency
        keys = 8'h01;
        for (int e = 1; e <= 4; e++) begin
            @(negedge CLK);
            chk($sformatf("latency_valid_e%0d", e), note_valid, (e >= 4) ? 1 : 0);
        end
        chk("k0_idx", note_idx, 0);
        chk("k0_led", Led, 8'h01);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (FREQ !== 1'b0) bad++;
            @(negedge CLK);
        end
        chk("k0_first_half_low", bad, 0);

        foreach (vecs[i]) begin
            keys = vecs[i].keys;
            mode = vecs[i].mode;
            repeat (5) @(negedge CLK);
            el = vecs[i].exp_valid ? (8'd1 << vecs[i].exp_idx) : 8'd0;
            chk($sformatf("vec%0d_valid", i), note_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_idx", i), note_idx, vecs[i].exp_idx);
            chk($sformatf("vec%0d_led", i), Led, el);
        end

        // silence with no keys in every mode
        keys = 8'h00;
        repeat (5) @(negedge CLK);
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            bad = 0;
            for (int i = 0; i < 250; i++) begin
                @(negedge CLK);
                if (FREQ !== 1'b0 || note_valid !== 1'b0) bad++;
            end
            chk($sformatf("idle_mode%0d", m), bad, 0);
        end

        // octave raised mid-note keeps the running count
        do_reset();
        keys = 8'h06;
        wait_valid(n);
        chk("oct2_idx", note_idx, 1);
        len = 0;
        while (FREQ == 1'b0 && len < 50000) begin
            len++;
            if (len == 100) octave = 2'd2;
            @(negedge CLK);
        end
        chk("oct2_half", len, 42565);

        // octave raised when the count already exceeds the new limit
        do_reset();
        keys = 8'h80;
        wait_valid(n);
        bad = 0;
        for (int i = 0; i < 12000; i++) begin
            if (FREQ !== 1'b0) bad++;
            @(negedge CLK);
        end
        chk("k7_low_before_shift", bad, 0);
        octave = 2'd3;
        @(negedge CLK);
        chk("k7_overshoot_toggle", FREQ, 1);

        // reset mid-half-cycle, then a clean restart
        repeat (100) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("midrst_freq", FREQ, 0);
        chk("midrst_led", Led, 0);
        chk("midrst_valid", note_valid, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        keys = 8'h80; octave = 2'd3;
        wait_valid(n);
        chk("midrst_latency", n, 4);
        run_len(1'b0, 20000, len);
        chk("k7o3_low_half", len, 11944);
        run_len(1'b1, 20000, len);
        chk("k7o3_high_half", len, 11944);

        // arpeggio stepping and release of the selected key
        do_reset();
        mode = 2'b10; keys = 8'h25;
        wait_valid(n);
        chk("arp_first", note_idx, 0);
        wait_change(n);
        chk("arp_step1_len", n, ARP);
        chk("arp_step1_idx", note_idx, 2);
        wait_change(n);
        chk("arp_step2_len", n, ARP);
        chk("arp_step2_idx", note_idx, 5);
        wait_change(n);
        chk("arp_step3_len", n, ARP);
        chk("arp_step3_idx", note_idx, 0);
        wait_change(n);
        chk("arp_step4_idx", note_idx, 2);
        keys = 8'h21;
        repeat (3) @(negedge CLK);
        chk("arp_release_hold", note_idx, 2);
        @(negedge CLK);
        chk("arp_release_next", note_idx, 5);
        wait_change(n);
        chk("arp_after_release_len", n, ARP);
        chk("arp_after_release_idx", note_idx, 0);

        // randomized run against the reference model
        do_reset();
        model_clear();
        octave = 2'($urandom);
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            el = e_valid ? (8'd1 << e_idx) : 8'd0;
            chk($sformatf("rand_c%0d", c), int'({note_valid, note_idx, Led, FREQ}),
                int'({e_valid, 3'(e_idx), el, e_freq}));
            if (hold == 0) begin
                keys = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
                hold = $urandom_range(1, 24);
            end else hold--;
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
            @(posedge CLK);
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
